// File: rtl/aes_dec_iter_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_iter_ctrl
//
// Iterative AES decryption sequencer. A single decrypt_round datapath instance
// is reused NR times. For each accepted ciphertext block the controller:
//   1. fetches round key NR from the key store and runs one decrypt_round pass,
//   2. repeats for keys NR-1 down to 1,
//   3. fetches key 0 and performs the final AddRoundKey itself,
//   4. presents the plaintext on the output handshake.
// Only one block is in flight at a time.
//
// Handshake semantics (both in_* and out_* sides):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer keeps valid and data stable until that edge; the
//   consumer may raise or drop ready at any time. ready without valid, or
//   valid without ready, has no effect.
//
// Parameters
//   NR         number of decrypt_round passes (10, 12 or 14)
//   KEY_LAT    cycles from key_rd_en high to key_rd_data valid (0 = comb.)
//   ROUND_LAT  cycles from stable rnd_in/rnd_key to valid rnd_out
//
// Ports
//   clk, rst_an                 clock (posedge) and synchronous active-low reset
//   in_valid/in_ready/in_data   ciphertext input handshake
//   out_valid/out_ready/out_data plaintext output handshake
//   key_rd_en/key_addr          key store read strobe and round-key index
//   key_rd_data                 round key returned by the key store
//   rnd_in/rnd_key/rnd_select   state, key and inverse-S-box select to decrypt_round
//   rnd_out                     result from decrypt_round
//   busy                        high whenever the controller is not IDLE
//
// Timing per block (cycles after the accept edge):
//   NR x (FETCH: KEY_LAT+1, EXEC: ROUND_LAT+1), then FIN_FETCH: KEY_LAT+1,
//   then DONE until the output handshake.
//
// The FSM state is held in state_q (type state_t) so external checkers can
// bind to it directly.
// -----------------------------------------------------------------------------
module aes_dec_iter_ctrl #(
    parameter int NR        = 10,
    parameter int KEY_LAT   = 1,
    parameter int ROUND_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_an,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         key_rd_en,
    output logic [3:0]   key_addr,
    input  logic [127:0] key_rd_data,
    output logic [127:0] rnd_in,
    output logic [127:0] rnd_key,
    output logic         rnd_select,
    input  logic [127:0] rnd_out,
    output logic         busy
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    // The phase counter only has to reach the longer of the two latencies.
    localparam int PMAX   = (KEY_LAT > ROUND_LAT) ? KEY_LAT : ROUND_LAT;
    localparam int PCNT_W = (PMAX < 2) ? 1 : $clog2(PMAX + 1);

    localparam logic [PCNT_W-1:0] KEY_LAST   = PCNT_W'(KEY_LAT);
    localparam logic [PCNT_W-1:0] ROUND_LAST = PCNT_W'(ROUND_LAT);
    localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);
    localparam logic [3:0]        NR_INIT    = 4'(NR);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        EXEC      = 3'd2,
        FIN_FETCH = 3'd3,
        DONE      = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [3:0]          rcnt_q,       rcnt_d;      // next round-key index
    logic [PCNT_W-1:0]   pcnt_q,       pcnt_d;      // cycle within FETCH/EXEC
    logic [127:0]        st_q,         st_d;        // working state
    logic [127:0]        key_q,        key_d;       // round key, doubles as rnd_key
    logic [127:0]        rnd_in_q,     rnd_in_d;
    logic [127:0]        out_q,        out_d;
    logic                in_ready_q,   in_ready_d;
    logic                out_valid_q,  out_valid_d;
    logic                key_rd_en_q,  key_rd_en_d;
    logic                rnd_select_q, rnd_select_d;
    logic                busy_q,       busy_d;

    logic fetch_last;
    logic exec_last;

    assign fetch_last = (pcnt_q == KEY_LAST);
    assign exec_last  = (pcnt_q == ROUND_LAST);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        pcnt_d       = pcnt_q + PCNT_ONE;
        st_d         = st_q;
        key_d        = key_q;
        rnd_in_d     = rnd_in_q;
        out_d        = out_q;

        unique case (state_q)
            IDLE: begin
                pcnt_d = '0;
                if (in_valid && in_ready_q) begin
                    st_d    = in_data;
                    rcnt_d  = NR_INIT;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (fetch_last) begin
                    // Key and state are loaded into the datapath-facing
                    // registers on the same edge, so both are stable for the
                    // whole EXEC phase.
                    key_d    = key_rd_data;
                    rnd_in_d = st_q;
                    pcnt_d   = '0;
                    state_d  = EXEC;
                end
            end

            EXEC: begin
                if (exec_last) begin
                    st_d     = rnd_out;
                    rcnt_d   = rcnt_q - 4'd1;
                    key_d    = '0;
                    rnd_in_d = '0;
                    pcnt_d   = '0;
                    // rcnt_q == 1 means the round just finished used key 1;
                    // only the final AddRoundKey with key 0 remains.
                    state_d  = (rcnt_q == 4'd1) ? FIN_FETCH : FETCH;
                end
            end

            FIN_FETCH: begin
                if (fetch_last) begin
                    out_d   = st_q ^ key_rd_data;
                    pcnt_d  = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                pcnt_d = '0;
                if (out_ready) begin
                    // Clearing here leaves IDLE with zero data outputs and
                    // key_addr parked at NR, the same as after reset.
                    out_d   = '0;
                    st_d    = '0;
                    rcnt_d  = NR_INIT;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase

        // Flag outputs are decoded from the next state so they are registered
        // and line up with the state they describe.
        in_ready_d   = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        out_valid_d  = (state_d == DONE);
        rnd_select_d = (state_d == EXEC);
        key_rd_en_d  = ((state_d == FETCH) || (state_d == FIN_FETCH)) &&
                       (pcnt_d == '0);
    end

    // -------------------------------------------------------------------------
    // Sequential logic (synchronous active-low reset wins over everything)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            state_q      <= IDLE;
            rcnt_q       <= NR_INIT;
            pcnt_q       <= '0;
            st_q         <= '0;
            key_q        <= '0;
            rnd_in_q     <= '0;
            out_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            key_rd_en_q  <= 1'b0;
            rnd_select_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            pcnt_q       <= pcnt_d;
            st_q         <= st_d;
            key_q        <= key_d;
            rnd_in_q     <= rnd_in_d;
            out_q        <= out_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            key_rd_en_q  <= key_rd_en_d;
            rnd_select_q <= rnd_select_d;
            busy_q       <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // rcnt is NR in IDLE, the round index in FETCH and 0 in FIN_FETCH/DONE,
    // which is exactly the key index the store has to see.
    assign key_addr   = rcnt_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_q;
    assign key_rd_en  = key_rd_en_q;
    assign rnd_in     = rnd_in_q;
    assign rnd_key    = key_q;
    assign rnd_select = rnd_select_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_iter_ctrl
//
// Two controller instances:
//   u_dut   : defaults (NR=10, KEY_LAT=1, ROUND_LAT=1), registered key store,
//             registered round stub rnd_out = rotl1(rnd_in) ^ rnd_key so that
//             a wrong key order changes the result.
//   u_dut_z : NR=10, KEY_LAT=0, ROUND_LAT=0, combinational key store and
//             combinational stub rnd_out = rnd_in ^ rnd_key.
// Key i is {16{i[7:0]}} for both.
// Latency is reported as the 1-based cycle number, counted from the cycle that
// starts at the accept edge, in which out_valid is first high.
// -----------------------------------------------------------------------------
module tb_aes_dec_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst_an;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic         key_rd_en, rnd_select, busy;
    logic [3:0]   key_addr;
    logic [127:0] key_rd_data = '0;
    logic [127:0] rnd_in, rnd_key;
    logic [127:0] rnd_out = '0;

    logic         in_valid_z, in_ready_z, out_valid_z, out_ready_z;
    logic [127:0] in_data_z, out_data_z;
    logic         key_rd_en_z, rnd_select_z, busy_z;
    logic [3:0]   key_addr_z;
    logic [127:0] key_rd_data_z;
    logic [127:0] rnd_in_z, rnd_key_z, rnd_out_z;

    int errors = 0;
    int checks = 0;
    int viol   = 0;
    logic [3:0] kq[$];
    logic [3:0] kqz[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    aes_dec_iter_ctrl u_dut (
        .clk(clk), .rst_an(rst_an),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_rd_en(key_rd_en), .key_addr(key_addr), .key_rd_data(key_rd_data),
        .rnd_in(rnd_in), .rnd_key(rnd_key), .rnd_select(rnd_select),
        .rnd_out(rnd_out), .busy(busy)
    );

    aes_dec_iter_ctrl #(.NR(10), .KEY_LAT(0), .ROUND_LAT(0)) u_dut_z (
        .clk(clk), .rst_an(rst_an),
        .in_valid(in_valid_z), .in_ready(in_ready_z), .in_data(in_data_z),
        .out_valid(out_valid_z), .out_ready(out_ready_z), .out_data(out_data_z),
        .key_rd_en(key_rd_en_z), .key_addr(key_addr_z), .key_rd_data(key_rd_data_z),
        .rnd_in(rnd_in_z), .rnd_key(rnd_key_z), .rnd_select(rnd_select_z),
        .rnd_out(rnd_out_z), .busy(busy_z)
    );

    // ---------------- environment models ----------------
    function automatic logic [127:0] key_of(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {16{b}};
    endfunction

    // Reference: NR passes of rotl1(s) ^ key[r] for r = 10..1, then ^ key[0].
    function automatic logic [127:0] model(input logic [127:0] ct);
        logic [127:0] s;
        s = ct;
        for (int r = 10; r >= 1; r--) s = {s[126:0], s[127]} ^ key_of(r);
        return s ^ key_of(0);
    endfunction

    always @(posedge clk) begin
        if (key_rd_en) key_rd_data <= key_of(int'(key_addr));
        rnd_out <= {rnd_in[126:0], rnd_in[127]} ^ rnd_key;
    end

    assign key_rd_data_z = key_of(int'(key_addr_z));
    assign rnd_out_z     = rnd_in_z ^ rnd_key_z;

    // Key-read logs and the "datapath inputs are zero outside EXEC" monitor.
    always @(negedge clk) begin
        if (key_rd_en === 1'b1)   kq.push_back(key_addr);
        if (key_rd_en_z === 1'b1) kqz.push_back(key_addr_z);
        if (rnd_select === 1'b0 && (rnd_in !== '0 || rnd_key !== '0)) viol++;
        if (rnd_select_z === 1'b0 && (rnd_in_z !== '0 || rnd_key_z !== '0)) viol++;
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns right after the accept edge (in_valid already high).
    task automatic wait_accept(output bit ok);
        bit rdy;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [127:0] blk_a, blk_b, blk_c, blk_d, blk_e, held, exp0b;
    int  cyc, nexec;
    bit  ok, prev_sel;

    initial begin
        blk_a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        blk_b = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        blk_c = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;
        blk_d = 128'h5555_5555_aaaa_aaaa_5555_5555_aaaa_aaaa;
        blk_e = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp0b = {16{8'h0B}};

        rst_an = 1'b0;
        in_valid = 1'b0;   in_data = '0;   out_ready = 1'b0;
        in_valid_z = 1'b0; in_data_z = '0; out_ready_z = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_key_rd_en", key_rd_en, 0);
        check("rst_rnd_select", rnd_select, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rnd_in", rnd_in, 0);
        check("rst_rnd_key", rnd_key, 0);
        check("rst_key_addr", key_addr, 10);
        check("rst_key_addr_z", key_addr_z, 10);
        check("rst_in_ready_z", in_ready_z, 1);
        rst_an = 1'b1;
        tick();

        // Block A: latency, key sequence, result; then 5 stalled DONE cycles
        kq.delete();
        in_valid = 1'b1; in_data = blk_a;
        wait_accept(ok);
        check("a_accept", ok, 1);
        in_valid = 1'b0; in_data = '0;
        check("a_busy", busy, 1);
        check("a_in_ready", in_ready, 0);
        check("a_first_key_rd", key_rd_en, 1);
        check("a_first_key_addr", key_addr, 10);
        wait_out(cyc);
        check("a_latency", cyc, 43);
        check("a_out_data", out_data, model(blk_a));
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, held);
            check("stall_in_ready", in_ready, 0);
            check("stall_busy", busy, 1);
        end
        check("a_key_reads", kq.size(), 11);
        for (int i = 0; i < kq.size() && i < 11; i++)
            check($sformatf("a_key_seq_%0d", i), kq[i], 10 - i);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_post_in_ready", in_ready, 1);
        check("a_post_out_valid", out_valid, 0);
        check("a_post_out_data", out_data, 0);
        check("a_post_busy", busy, 0);
        check("a_post_key_addr", key_addr, 10);

        // Blocks B and C back to back with in_valid held high
        kq.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = blk_b;
        wait_accept(ok);
        check("b_accept", ok, 1);
        in_data = blk_c;                       // must not disturb block B
        wait_out(cyc);
        check("b_latency", cyc, 43);
        check("b_out_data", out_data, model(blk_b));
        tick();                                // output handshake edge
        check("bc_gap_in_ready", in_ready, 1);
        check("bc_gap_out_valid", out_valid, 0);
        check("bc_gap_key_rd_en", key_rd_en, 0);
        tick();                                // second accept edge
        in_valid = 1'b0;
        check("c_busy", busy, 1);
        check("c_first_key_rd", key_rd_en, 1);
        check("c_first_key_addr", key_addr, 10);
        wait_out(cyc);
        check("c_latency", cyc, 43);
        check("c_out_data", out_data, model(blk_c));
        tick();
        out_ready = 1'b0;
        check("bc_key_reads", kq.size(), 22);
        for (int i = 0; i < kq.size() && i < 22; i++)
            check($sformatf("bc_key_seq_%0d", i), kq[i], 10 - (i % 11));

        // Block D: reset pulse during the 5th EXEC
        in_valid = 1'b1; in_data = blk_d;
        wait_accept(ok);
        check("d_accept", ok, 1);
        in_valid = 1'b0;
        nexec = 0; prev_sel = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rnd_select && !prev_sel) nexec++;
            prev_sel = rnd_select;
            if (nexec == 5) break;
            tick();
        end
        check("d_reached_exec5", nexec, 5);
        check("d_exec5_rnd_select", rnd_select, 1);
        rst_an = 1'b0;
        tick();
        rst_an = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_key_rd_en", key_rd_en, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rnd_in", rnd_in, 0);
        check("midrst_key_addr", key_addr, 10);

        // Block E: clean run after the mid-block reset
        kq.delete();
        in_valid = 1'b1; in_data = blk_e;
        wait_accept(ok);
        check("e_accept", ok, 1);
        in_valid = 1'b0;
        wait_out(cyc);
        check("e_latency", cyc, 43);
        check("e_out_data", out_data, model(blk_e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("e_key_reads", kq.size(), 11);

        // Zero-latency instance, XOR stub, ciphertext 0 -> {16{8'h0B}}
        kqz.delete();
        in_valid_z = 1'b1; in_data_z = '0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bit rdy;
            rdy = in_ready_z;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("z_accept", ok, 1);
        in_valid_z = 1'b0;
        check("z_first_key_rd", key_rd_en_z, 1);
        cyc = 1;
        while (out_valid_z !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("z_latency", cyc, 22);
        check("z_out_data", out_data_z, exp0b);
        check("z_key_reads", kqz.size(), 11);
        for (int i = 0; i < kqz.size() && i < 11; i++)
            check($sformatf("z_key_seq_%0d", i), kqz[i], 10 - i);
        out_ready_z = 1'b1;
        tick();
        out_ready_z = 1'b0;
        check("z_post_in_ready", in_ready_z, 1);
        check("z_post_out_valid", out_valid_z, 0);

        check("rnd_zero_outside_exec", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
